// File: rtl/cr_im_bank_writer_if.sv
// Record capture, bank handshake and read-back signals for the instrumentation bank writer.
// The engine/reader side uses the master modport; the bank writer uses the slave modport.
interface cr_im_bank_writer_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              rec_valid;
    logic [DATA_W-1:0] rec_data;
    logic              flush;
    logic [1:0]        im_available;
    logic [ADDR_W:0]   im_cnt0;
    logic [ADDR_W:0]   im_cnt1;
    logic [1:0]        im_consumed;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [15:0]       drop_cnt;
    logic              im_ovf_int;

    modport master (
        output rec_valid, rec_data, flush, im_consumed, rd_en, rd_bank, rd_addr,
        input  im_available, im_cnt0, im_cnt1, rd_valid, rd_data, drop_cnt, im_ovf_int
    );

    modport slave (
        input  rec_valid, rec_data, flush, im_consumed, rd_en, rd_bank, rd_addr,
        output im_available, im_cnt0, im_cnt1, rd_valid, rd_data, drop_cnt, im_ovf_int
    );
endinterface

// File: rtl/cr_im_bank_writer.sv
// Ping-pong instrumentation memory writer: fills one bank while the other is read out,
// hands closed banks to the reader and drops records while both banks are pending.
module cr_im_bank_writer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    cr_im_bank_writer_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] BANK_FREE    = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_AVAIL   = 2'd2;

    localparam logic [0:0] WR_ACTIVE  = 1'b0;
    localparam logic [0:0] WR_STALLED = 1'b1;

    logic [0:0]        wr_state_reg;
    logic              wr_bank_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic              last_closed_reg;
    logic [15:0]       drop_cnt_reg;
    logic              ovf_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic [1:0]        consume_hit;
    logic [1:0]        bank_free;
    logic [1:0]        bank_avail;
    logic [ADDR_W:0]   bank_cnt [2];

    logic [ADDR_W:0]   cur_cnt;
    logic              wr_fire;
    logic              wr_close;
    logic              drop;

    always_comb begin
        cur_cnt  = bank_cnt[wr_bank_reg];
        wr_fire  = (wr_state_reg == WR_ACTIVE) && bus.rec_valid;
        // A flush closes the bank if it ends up non-empty, counting a same-cycle record.
        wr_close = (wr_state_reg == WR_ACTIVE) &&
                   ((wr_fire && (cur_cnt == (ADDR_W+1)'(DEPTH - 1))) ||
                    (bus.flush && ((cur_cnt != '0) || wr_fire)));
        drop     = (wr_state_reg == WR_STALLED) && bus.rec_valid;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [1:0]      state_reg;
            logic [ADDR_W:0] cnt_reg;
            logic            mine;

            assign mine            = (wr_bank_reg == 1'(gi));
            assign consume_hit[gi] = bus.im_consumed[gi] && (state_reg == BANK_AVAIL);
            // A bank being released this cycle counts as free so a closing writer can take it.
            assign bank_free[gi]   = (state_reg == BANK_FREE) || consume_hit[gi];
            assign bank_avail[gi]  = (state_reg == BANK_AVAIL);
            assign bank_cnt[gi]    = cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= BANK_FREE;
                    cnt_reg   <= '0;
                end else if (consume_hit[gi]) begin
                    state_reg <= BANK_FREE;
                    cnt_reg   <= '0;
                end else if (mine && wr_close) begin
                    state_reg <= BANK_AVAIL;
                    cnt_reg   <= cnt_reg + {{ADDR_W{1'b0}}, wr_fire};
                end else if (mine && wr_fire) begin
                    state_reg <= BANK_FILLING;
                    cnt_reg   <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg    <= WR_ACTIVE;
            wr_bank_reg     <= 1'b0;
            wr_addr_reg     <= '0;
            last_closed_reg <= 1'b0;
            drop_cnt_reg    <= '0;
            ovf_reg         <= 1'b0;
        end else begin
            ovf_reg <= drop;
            if (drop && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (wr_state_reg == WR_ACTIVE) begin
                if (wr_close) begin
                    last_closed_reg <= wr_bank_reg;
                    wr_addr_reg     <= '0;
                    if (bank_free[~wr_bank_reg]) begin
                        wr_bank_reg <= ~wr_bank_reg;
                    end else begin
                        wr_state_reg <= WR_STALLED;
                    end
                end else if (wr_fire) begin
                    wr_addr_reg <= wr_addr_reg + 1'b1;
                end
            end else if (|consume_hit) begin
                // With both banks released, restart on the older one.
                wr_state_reg <= WR_ACTIVE;
                wr_addr_reg  <= '0;
                wr_bank_reg  <= (&consume_hit) ? ~last_closed_reg : consume_hit[1];
            end
        end
    end

    logic [DATA_W-1:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_reg, wr_addr_reg}] <= bus.rec_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_reg <= mem[{bus.rd_bank, bus.rd_addr}];
            end
        end
    end

    assign bus.im_available = bank_avail;
    assign bus.im_cnt0      = bank_cnt[0];
    assign bus.im_cnt1      = bank_cnt[1];
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.rd_data      = rd_data_reg;
    assign bus.drop_cnt     = drop_cnt_reg;
    assign bus.im_ovf_int   = ovf_reg;
endmodule

// File: tb/tb_cr_im_bank_writer.sv
// Directed bench for cr_im_bank_writer at DEPTH=4: a bank-level reference model is
// compared every cycle, plus hand-computed expectations at key points of the scenario.
module tb_cr_im_bank_writer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr_im_bank_writer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    cr_im_bank_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-bank "available" flag and record count, the bank being filled
    // (-1 while every bank is waiting on the reader), and a flat copy of the memory.
    logic [DATA_W-1:0] m_mem [2*DEPTH];
    bit                m_known [2*DEPTH];
    bit                m_avail [2];
    int                m_cnt [2];
    int                m_fill, m_last, m_drop;
    bit                m_ovf, m_rdv, m_rdk, model_ok = 0;
    logic [DATA_W-1:0] m_rdd;

    always @(posedge clk) begin
        bit freed [2];
        int a, other;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin m_avail[b] = 0; m_cnt[b] = 0; end
            m_fill = 0; m_last = 0; m_drop = 0; m_ovf = 0;
            m_rdv = 0; m_rdd = '0; m_rdk = 1;
            model_ok = 1;
        end else begin
            if (bus.rd_en) begin
                a = int'(bus.rd_bank) * DEPTH + int'(bus.rd_addr);
                m_rdd = m_mem[a];
                m_rdk = m_known[a];
            end
            m_rdv = bus.rd_en;
            for (int b = 0; b < 2; b++) freed[b] = bus.im_consumed[b] && m_avail[b];
            m_ovf = 0;
            if (m_fill < 0) begin
                if (bus.rec_valid) begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                if (freed[0] || freed[1])
                    m_fill = (freed[0] && freed[1]) ? 1 - m_last : (freed[1] ? 1 : 0);
            end else begin
                if (bus.rec_valid) begin
                    a = m_fill * DEPTH + m_cnt[m_fill];
                    m_mem[a] = bus.rec_data;
                    m_known[a] = 1;
                    m_cnt[m_fill]++;
                end
                if (m_cnt[m_fill] == DEPTH || (bus.flush && m_cnt[m_fill] > 0)) begin
                    other = 1 - m_fill;
                    m_avail[m_fill] = 1;
                    m_last = m_fill;
                    m_fill = (!m_avail[other] || freed[other]) ? other : -1;
                end
            end
            for (int b = 0; b < 2; b++) if (freed[b]) begin m_avail[b] = 0; m_cnt[b] = 0; end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cyc_avail", bus.im_available, {m_avail[1], m_avail[0]});
            check("cyc_cnt0", bus.im_cnt0, m_cnt[0]);
            check("cyc_cnt1", bus.im_cnt1, m_cnt[1]);
            check("cyc_drop", bus.drop_cnt, m_drop);
            check("cyc_ovf", bus.im_ovf_int, m_ovf);
            check("cyc_rd_valid", bus.rd_valid, m_rdv);
            if (m_rdk) check("cyc_rd_data", bus.rd_data, m_rdd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string what);
        $display("%s: avail=%b cnt0=%0d cnt1=%0d drop=%0d ovf=%0d rd_valid=%0d rd_data=%h",
                 what, bus.im_available, bus.im_cnt0, bus.im_cnt1, bus.drop_cnt,
                 bus.im_ovf_int, bus.rd_valid, bus.rd_data);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic fl);
        bus.rec_valid = 1'b1; bus.rec_data = d; bus.flush = fl;
        tick();
        bus.rec_valid = 1'b0; bus.flush = 1'b0;
        show($sformatf("push %h flush=%0d", d, fl));
    endtask

    task automatic consume(input logic [1:0] m);
        bus.im_consumed = m;
        tick();
        bus.im_consumed = 2'b00;
        show($sformatf("consume %b", m));
    endtask

    task automatic rd(input logic b, input logic [1:0] a, input logic [DATA_W-1:0] exp, input string nm);
        bus.rd_en = 1'b1; bus.rd_bank = b; bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
        show($sformatf("read bank%0d[%0d]", b, a));
        check({nm, "_valid"}, bus.rd_valid, 1);
        check(nm, bus.rd_data, exp);
    endtask

    initial begin
        bus.rec_valid = 0; bus.rec_data = '0; bus.flush = 0; bus.im_consumed = 2'b00;
        bus.rd_en = 0; bus.rd_bank = 0; bus.rd_addr = '0;
        tick(); tick();
        check("rst_avail", bus.im_available, 2'b00);
        check("rst_cnt0", bus.im_cnt0, 0);
        check("rst_drop", bus.drop_cnt, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        rst = 1'b0;

        // Full bank closes, next record lands in bank 1 at addr 0
        for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i), 1'b0);
        check("full_avail", bus.im_available, 2'b01);
        check("full_cnt0", bus.im_cnt0, 4);
        push(16'hA004, 1'b0);
        check("rec5_cnt1", bus.im_cnt1, 1);
        rd(1'b1, 2'd0, 16'hA004, "rec5_bank1_addr0");
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1'b1; bus.rd_bank = 1'b0; bus.rd_addr = 2'(i);
            tick();
            show($sformatf("burst read bank0[%0d]", i));
            check("burst_valid", bus.rd_valid, 1);
            check("burst_data", bus.rd_data, 16'hA000 + 16'(i));
        end
        bus.rd_en = 1'b0;

        // Release bank 0, then close bank 1 early with 3 entries
        consume(2'b01);
        check("rel0_cnt0", bus.im_cnt0, 0);
        push(16'hA005, 1'b0);
        push(16'hA006, 1'b0);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0; show("flush");
        check("flush_avail", bus.im_available, 2'b10);
        check("flush_cnt1", bus.im_cnt1, 3);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0; show("flush empty");
        check("flush0_avail", bus.im_available, 2'b10);
        check("flush0_cnt0", bus.im_cnt0, 0);

        // Flush together with the 2nd record
        push(16'hB000, 1'b0);
        push(16'hB001, 1'b1);
        check("flushrec_cnt0", bus.im_cnt0, 2);
        check("flushrec_avail", bus.im_available, 2'b11);

        // Both banks pending: records are dropped
        for (int i = 0; i < 3; i++) begin
            push(16'hBAD0 + 16'(i), 1'b0);
            check("drop_ovf", bus.im_ovf_int, 1);
        end
        tick(); show("idle");
        check("drop_ovf_end", bus.im_ovf_int, 0);
        check("drop_cnt3", bus.drop_cnt, 3);

        // Release with a same-cycle record: record still dropped, writing resumes on bank 0
        bus.im_consumed = 2'b01; bus.rec_valid = 1'b1; bus.rec_data = 16'hBAD9;
        tick();
        bus.im_consumed = 2'b00; bus.rec_valid = 1'b0; show("consume+rec");
        check("relrec_drop", bus.drop_cnt, 4);
        push(16'hC000, 1'b0);
        check("resume_cnt0", bus.im_cnt0, 1);
        rd(1'b0, 2'd0, 16'hC000, "resume_bank0_addr0");

        // Stray release of a filling bank is ignored
        consume(2'b10);
        for (int i = 1; i < 4; i++) push(16'hC000 + 16'(i), 1'b0);
        check("fill0_avail", bus.im_available, 2'b01);
        push(16'hD000, 1'b0);
        consume(2'b10);
        check("stray_cnt1", bus.im_cnt1, 1);
        check("stray_avail", bus.im_available, 2'b01);
        push(16'hD001, 1'b0);

        // Read and write of the same entry in one cycle returns the old contents
        bus.rd_en = 1'b1; bus.rd_bank = 1'b1; bus.rd_addr = 2'd2;
        bus.rec_valid = 1'b1; bus.rec_data = 16'hD002;
        tick();
        bus.rd_en = 1'b0; bus.rec_valid = 1'b0; show("read+write bank1[2]");
        check("rw_old_data", bus.rd_data, 16'hA006);
        rd(1'b1, 2'd2, 16'hD002, "rw_new_data");

        // Last entry together with flush closes the bank once
        push(16'hD003, 1'b1);
        check("lastflush_cnt1", bus.im_cnt1, 4);
        check("lastflush_avail", bus.im_available, 2'b11);

        // Release both while stalled: resume on the bank closed earlier (bank 0)
        consume(2'b11);
        check("both_avail", bus.im_available, 2'b00);
        push(16'hE000, 1'b0);
        check("both_cnt0", bus.im_cnt0, 1);
        check("both_cnt1", bus.im_cnt1, 0);
        rd(1'b0, 2'd0, 16'hE000, "both_bank0_addr0");

        // Reset mid-operation with both banks pending
        for (int i = 1; i < 8; i++) push(16'hE000 + 16'(i), 1'b0);
        check("pre_rst_avail", bus.im_available, 2'b11);
        rst = 1'b1; tick(); rst = 1'b0; show("reset pulse");
        check("mid_rst_avail", bus.im_available, 2'b00);
        check("mid_rst_cnt1", bus.im_cnt1, 0);
        check("mid_rst_drop", bus.drop_cnt, 0);
        push(16'hF000, 1'b0);
        check("post_rst_cnt0", bus.im_cnt0, 1);
        rd(1'b0, 2'd0, 16'hF000, "post_rst_bank0_addr0");
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
